// File: rtl/poly_arith_pkg.sv
// Shared types and constants for arithmetic over Z_3329 (ML-KEM coefficient ring).
package poly_arith_pkg;

  localparam int unsigned Q      = 3329;
  localparam int unsigned CoeffW = 12;

  typedef logic [CoeffW-1:0] coeff_t;

  typedef enum logic [1:0] {
    OP_ADD      = 2'b00,
    OP_SUB      = 2'b01,
    OP_ACC_ADD  = 2'b10,
    OP_ACC_LOAD = 2'b11
  } add_sub_op_e;

  // Single conditional subtract; valid for s in [0, 2Q-1].
  function automatic coeff_t mod_reduce(input logic [CoeffW:0] s);
    logic [CoeffW:0] w_diff;
    w_diff = s - (CoeffW+1)'(Q);
    return (s >= (CoeffW+1)'(Q)) ? w_diff[CoeffW-1:0] : s[CoeffW-1:0];
  endfunction

endpackage

// File: rtl/mod_uni_add_sub.sv
// Combinational (a +/- b) mod Q for one coefficient; operands assumed in [0, Q-1].
module mod_uni_add_sub
  import poly_arith_pkg::*;
(
  input  coeff_t a_i,
  input  coeff_t b_i,
  input  logic   is_sub_i,
  output coeff_t res_o
);

  logic [CoeffW:0] w_b_term;
  logic [CoeffW:0] w_sum;

  // Subtraction as a + (Q - b) keeps the sum non-negative and below 2Q.
  always_comb begin
    w_b_term = is_sub_i ? ((CoeffW+1)'(Q) - {1'b0, b_i}) : {1'b0, b_i};
    w_sum    = {1'b0, a_i} + w_b_term;
    res_o    = mod_reduce(w_sum);
  end

endmodule

// File: rtl/mod_vec_add_sub_pipe.sv
// LANES-wide two-stage modular add/sub/accumulate pipeline over Z_3329 with valid/ready.
module mod_vec_add_sub_pipe
  import poly_arith_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [LANES*12-1:0]   op1_i,
  input  logic [LANES*12-1:0]   op2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES*12-1:0]   result_o,
  output logic [1:0]            out_op_o
);

  logic                r_s1_valid;
  add_sub_op_e         r_s1_op;
  logic [LANES*12-1:0] r_s1_a;
  logic [LANES*12-1:0] r_s1_b;
  logic                r_s2_valid;
  logic [LANES*12-1:0] r_result;
  logic [1:0]          r_out_op;

  logic                w_s2_take;
  logic                w_in_fire;
  logic [LANES*12-1:0] w_lane_res;

  assign w_s2_take  = r_s1_valid & (~r_s2_valid | out_ready_i);
  assign in_ready_o = ~r_s1_valid | w_s2_take;
  assign w_in_fire  = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_out_op   <= 2'b00;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= add_sub_op_e'(op_i);
        r_s1_a     <= op1_i;
        r_s1_b     <= op2_i;
      end else if (w_s2_take) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_take) begin
        r_s2_valid <= 1'b1;
        r_result   <= w_lane_res;
        r_out_op   <= r_s1_op;
      end else if (out_ready_i) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    coeff_t w_a;
    coeff_t w_b;
    coeff_t w_acc;
    coeff_t w_u_op1;
    coeff_t w_u_op2;
    coeff_t w_u_res;
    logic   w_acc_op;

    assign w_a      = r_s1_a[12*l +: 12];
    assign w_b      = r_s1_b[12*l +: 12];
    assign w_acc_op = ACC_EN && (r_s1_op == OP_ACC_ADD);
    assign w_u_op1  = w_acc_op ? w_acc : w_a;
    assign w_u_op2  = w_acc_op ? w_a : w_b;

    mod_uni_add_sub u_add_sub (
      .a_i      (w_u_op1),
      .b_i      (w_u_op2),
      .is_sub_i (r_s1_op == OP_SUB),
      .res_o    (w_u_res)
    );

    assign w_lane_res[12*l +: 12] = (r_s1_op == OP_ACC_LOAD) ? w_a : w_u_res;

    if (ACC_EN) begin : g_acc
      coeff_t r_acc;

      // Commit only when the beat leaves S1 so a stalled beat is never counted twice.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_acc <= '0;
        end else if (w_s2_take) begin
          if (r_s1_op == OP_ACC_ADD) begin
            r_acc <= w_u_res;
          end else if (r_s1_op == OP_ACC_LOAD) begin
            r_acc <= w_a;
          end
        end
      end

      assign w_acc = r_acc;
    end else begin : g_no_acc
      assign w_acc = '0;
    end
  end

  assign out_valid_o = r_s2_valid;
  assign result_o    = r_result;
  assign out_op_o    = r_out_op;

endmodule

// File: tb/tb_mod_vec_add_sub_pipe.sv
// Directed bench for mod_vec_add_sub_pipe: arithmetic corners, accumulator, backpressure, reset.
module tb_mod_vec_add_sub_pipe;

  localparam int LANES = 4;
  localparam int W     = LANES * 12;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [1:0]   op_i;
  logic [W-1:0] op1_i;
  logic [W-1:0] op2_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] result_o;
  logic [1:0]   out_op_o;

  int checks = 0;
  int errors = 0;

  logic [1:0]   s_op  [8];
  logic [W-1:0] s_a   [8];
  logic [W-1:0] s_b   [8];
  logic [W-1:0] s_exp [8];
  int           s_n;

  always #5 clk = ~clk;

  mod_vec_add_sub_pipe #(
    .LANES  (LANES),
    .ACC_EN (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .out_op_o    (out_op_o)
  );

  function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {12'(l3), 12'(l2), 12'(l1), 12'(l0)};
  endfunction

  function automatic logic [W-1:0] rep4(input int v);
    return pack4(v, v, v, v);
  endfunction

  function automatic int golden(input int a, input int b, input bit sub);
    int s;
    s = sub ? a - b : a + b;
    return ((s % 3329) + 3329) % 3329;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives s_* beats, applies a stall window [st0, st1) on out_ready_i.
  task automatic run_stream(input string tag, input int st0, input int st1);
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    int last_out = -1;
    bit have_held = 1'b0;
    bit fin;
    bit fout;
    logic [W-1:0] held;
    while (recv < s_n && cyc < 40) begin
      out_ready_i = !(cyc >= st0 && cyc < st1);
      if (sent < s_n) begin
        for (int l = 0; l < LANES; l++) begin
          assert (s_a[sent][12*l +: 12] < 12'd3329 && s_b[sent][12*l +: 12] < 12'd3329)
            else $fatal(1, "illegal operand in %s", tag);
        end
        in_valid_i = 1'b1;
        op_i       = s_op[sent];
        op1_i      = s_a[sent];
        op2_i      = s_b[sent];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (!out_ready_i && out_valid_o) begin
        if (have_held) check({tag, " held"}, result_o, held);
        held      = result_o;
        have_held = 1'b1;
        if (sent - recv >= 2) check({tag, " in_ready low"}, W'(in_ready_o), W'(0));
      end else begin
        have_held = 1'b0;
      end
      fin  = in_valid_i && in_ready_o;
      fout = out_valid_o && out_ready_i;
      if (fout) begin
        check({tag, " result"}, result_o, s_exp[recv]);
        check({tag, " out_op"}, W'(out_op_o), W'(s_op[recv]));
        recv++;
        last_out = cyc;
      end
      if (fin) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    check({tag, " count"}, W'(recv), W'(s_n));
    if (st0 == st1) check({tag, " latency/throughput"}, W'(last_out), W'(s_n + 1));
    #1;
    check({tag, " drained"}, W'(out_valid_o), W'(0));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    op_i        = 2'b00;
    op1_i       = '0;
    op2_i       = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset out_valid", W'(out_valid_o), W'(0));
    check("reset result", result_o, W'(0));
    check("reset out_op", W'(out_op_o), W'(0));
    rst_i = 1'b0;
    #1;
    check("reset in_ready", W'(in_ready_o), W'(1));
    @(negedge clk);

    // ADD corners, single beat
    s_n = 1;
    s_op[0]  = 2'b00;
    s_a[0]   = pack4(3328, 0, 1664, 3000);
    s_b[0]   = pack4(3328, 0, 1665, 328);
    s_exp[0] = pack4(3327, 0, 0, 3328);
    run_stream("add", 0, 0);

    // SUB corners, single beat
    s_op[0]  = 2'b01;
    s_a[0]   = pack4(0, 5, 3328, 100);
    s_b[0]   = pack4(1, 5, 0, 3328);
    s_exp[0] = pack4(3328, 0, 3328, 101);
    run_stream("sub", 0, 0);

    // Back-to-back accumulator traffic with an interleaved ADD
    s_n = 5;
    s_op[0] = 2'b11; s_a[0] = rep4(3000); s_b[0] = rep4(0); s_exp[0] = rep4(3000);
    s_op[1] = 2'b10; s_a[1] = rep4(500);  s_b[1] = rep4(0); s_exp[1] = rep4(171);
    s_op[2] = 2'b10; s_a[2] = rep4(3328); s_b[2] = rep4(0); s_exp[2] = rep4(170);
    s_op[3] = 2'b00; s_a[3] = rep4(1);    s_b[3] = rep4(1); s_exp[3] = rep4(2);
    s_op[4] = 2'b10; s_a[4] = rep4(1);    s_b[4] = rep4(0); s_exp[4] = rep4(171);
    run_stream("acc b2b", 0, 0);

    // Backpressure: four ADD beats, downstream stalled for four cycles
    s_n = 4;
    for (int i = 0; i < 4; i++) begin
      s_op[i]  = 2'b00;
      s_a[i]   = pack4(i + 1, i + 11, i + 21, i + 31);
      s_b[i]   = rep4(0);
      s_exp[i] = pack4(i + 1, i + 11, i + 21, i + 31);
    end
    run_stream("backpressure", 0, 4);

    // Stalled accumulator beat must not be counted twice
    s_n = 3;
    s_op[0] = 2'b11; s_a[0] = rep4(10); s_b[0] = rep4(0); s_exp[0] = rep4(10);
    s_op[1] = 2'b10; s_a[1] = rep4(5);  s_b[1] = rep4(0); s_exp[1] = rep4(15);
    s_op[2] = 2'b10; s_a[2] = rep4(0);  s_b[2] = rep4(0); s_exp[2] = rep4(15);
    run_stream("acc stall", 0, 3);

    // Pseudo-random ADD/SUB against the golden model, with a stall window
    s_n = 6;
    for (int i = 0; i < 6; i++) begin
      int av [4];
      int bv [4];
      int ev [4];
      s_op[i] = 2'($urandom_range(0, 1));
      for (int l = 0; l < 4; l++) begin
        av[l] = int'($urandom_range(0, 3328));
        bv[l] = int'($urandom_range(0, 3328));
        ev[l] = golden(av[l], bv[l], s_op[i][0]);
      end
      s_a[i]   = pack4(av[0], av[1], av[2], av[3]);
      s_b[i]   = pack4(bv[0], bv[1], bv[2], bv[3]);
      s_exp[i] = pack4(ev[0], ev[1], ev[2], ev[3]);
    end
    run_stream("random", 2, 5);

    // Reset with two accumulator beats in flight
    in_valid_i = 1'b1;
    op_i       = 2'b11;
    op1_i      = rep4(100);
    op2_i      = rep4(0);
    @(negedge clk);
    op_i  = 2'b10;
    op1_i = rep4(1);
    @(negedge clk);
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midreset out_valid", W'(out_valid_o), W'(0));
    check("midreset result", result_o, W'(0));
    @(negedge clk);
    @(negedge clk);
    check("midreset no stray beat", W'(out_valid_o), W'(0));
    s_n = 1;
    s_op[0] = 2'b10; s_a[0] = rep4(7); s_b[0] = rep4(0); s_exp[0] = rep4(7);
    run_stream("acc after reset", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
